// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: standard resolution timing sets,
// sync polarity constants and the 8-entry colour bar table.
package video_timing_pkg;

   localparam int CNT_W = 16;

   typedef struct packed {
      logic [15:0] h_sync;
      logic [15:0] h_back;
      logic [15:0] h_disp;
      logic [15:0] h_front;
      logic [15:0] v_sync;
      logic [15:0] v_back;
      logic [15:0] v_disp;
      logic [15:0] v_front;
   } timing_t;

   localparam bit POL_POS = 1'b1;
   localparam bit POL_NEG = 1'b0;

   localparam timing_t T_480X272 = '{
      h_sync: 16'd41, h_back: 16'd2, h_disp: 16'd480, h_front: 16'd2,
      v_sync: 16'd10, v_back: 16'd2, v_disp: 16'd272, v_front: 16'd2};

   localparam timing_t T_640X480 = '{
      h_sync: 16'd96, h_back: 16'd48, h_disp: 16'd640, h_front: 16'd16,
      v_sync: 16'd2, v_back: 16'd33, v_disp: 16'd480, v_front: 16'd10};

   localparam timing_t T_800X480 = '{
      h_sync: 16'd128, h_back: 16'd88, h_disp: 16'd800, h_front: 16'd40,
      v_sync: 16'd2, v_back: 16'd33, v_disp: 16'd480, v_front: 16'd10};

   localparam timing_t T_800X600 = '{
      h_sync: 16'd128, h_back: 16'd88, h_disp: 16'd800, h_front: 16'd40,
      v_sync: 16'd4, v_back: 16'd23, v_disp: 16'd600, v_front: 16'd1};

   localparam timing_t T_1024X768 = '{
      h_sync: 16'd136, h_back: 16'd160, h_disp: 16'd1024, h_front: 16'd24,
      v_sync: 16'd6, v_back: 16'd29, v_disp: 16'd768, v_front: 16'd3};

   localparam timing_t T_1280X720 = '{
      h_sync: 16'd40, h_back: 16'd220, h_disp: 16'd1280, h_front: 16'd110,
      v_sync: 16'd5, v_back: 16'd20, v_disp: 16'd720, v_front: 16'd5};

   localparam timing_t T_1920X1080 = '{
      h_sync: 16'd44, h_back: 16'd148, h_disp: 16'd1920, h_front: 16'd88,
      v_sync: 16'd5, v_back: 16'd36, v_disp: 16'd1080, v_front: 16'd4};

   // {r, g, b} per bar: white, yellow, cyan, green,
   // magenta, red, blue, black.
   localparam logic [2:0] BAR_TABLE [8] = '{
      3'b111, 3'b110, 3'b011, 3'b010,
      3'b101, 3'b100, 3'b001, 3'b000};

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters with unregistered hs/vs/de decode.
// Ports: clk, rst_n in; h_cnt, v_cnt, hs, vs, de out.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_SYNC  = 41,
   parameter int H_BACK  = 2,
   parameter int H_DISP  = 480,
   parameter int H_FRONT = 2,
   parameter bit HS_POL  = POL_POS,
   parameter int V_SYNC  = 10,
   parameter int V_BACK  = 2,
   parameter int V_DISP  = 272,
   parameter int V_FRONT = 2,
   parameter bit VS_POL  = POL_POS
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             hs,
   output logic             vs,
   output logic             de
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] HA_BEG = CNT_W'(H_SYNC + H_BACK);
   localparam logic [CNT_W-1:0] HA_END = CNT_W'(H_SYNC + H_BACK + H_DISP);
   localparam logic [CNT_W-1:0] VA_BEG = CNT_W'(V_SYNC + V_BACK);
   localparam logic [CNT_W-1:0] VA_END = CNT_W'(V_SYNC + V_BACK + V_DISP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   logic h_act;
   logic v_act;

   always_comb begin
      h_act = (h_cnt >= HA_BEG) && (h_cnt < HA_END);
      v_act = (v_cnt >= VA_BEG) && (v_cnt < VA_END);
      hs    = (h_cnt < HS_END) ? HS_POL : ~HS_POL;
      vs    = (v_cnt < VS_END) ? VS_POL : ~VS_POL;
      de    = h_act && v_act;
   end

endmodule

// File: rtl/video_color_bar_gen.sv
// 8-bar colour test pattern source with registered hs/vs/de/rgb.
// Ports: clk, rst_n in; hs, vs, de, rgb_r, rgb_g, rgb_b out.
module video_color_bar_gen
   import video_timing_pkg::*;
#(
   parameter int H_SYNC     = int'(T_480X272.h_sync),
   parameter int H_BACK     = int'(T_480X272.h_back),
   parameter int H_DISP     = int'(T_480X272.h_disp),
   parameter int H_FRONT    = int'(T_480X272.h_front),
   parameter bit HS_POL     = POL_POS,
   parameter int V_SYNC     = int'(T_480X272.v_sync),
   parameter int V_BACK     = int'(T_480X272.v_back),
   parameter int V_DISP     = int'(T_480X272.v_disp),
   parameter int V_FRONT    = int'(T_480X272.v_front),
   parameter bit VS_POL     = POL_POS,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  hs,
   output logic                  vs,
   output logic                  de,
   output logic [DATA_WIDTH-1:0] rgb_r,
   output logic [DATA_WIDTH-1:0] rgb_g,
   output logic [DATA_WIDTH-1:0] rgb_b
);

   localparam int BAR_W_RAW = H_DISP / 8;
   // Guard the divider for degenerate widths below 8 pixels.
   localparam int BAR_W     = (BAR_W_RAW < 1) ? 1 : BAR_W_RAW;
   localparam logic [CNT_W-1:0] HA_BEG = CNT_W'(H_SYNC + H_BACK);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             hs_c;
   logic             vs_c;
   logic             de_c;

   video_timing_gen #(
      .H_SYNC (H_SYNC),
      .H_BACK (H_BACK),
      .H_DISP (H_DISP),
      .H_FRONT(H_FRONT),
      .HS_POL (HS_POL),
      .V_SYNC (V_SYNC),
      .V_BACK (V_BACK),
      .V_DISP (V_DISP),
      .V_FRONT(V_FRONT),
      .VS_POL (VS_POL)
   ) u_timing (
      .clk  (clk),
      .rst_n(rst_n),
      .h_cnt(h_cnt),
      .v_cnt(v_cnt),
      .hs   (hs_c),
      .vs   (vs_c),
      .de   (de_c)
   );

   // Pattern is line-invariant, so the row counter is not needed here.
   logic unused_v;
   assign unused_v = ^v_cnt;

   logic [CNT_W-1:0] x;
   logic [CNT_W-1:0] bar_q;
   logic [2:0]       bar;
   logic [2:0]       color;

   always_comb begin
      // x is meaningless outside active video; de masks it below.
      x     = h_cnt - HA_BEG;
      bar_q = x / CNT_W'(BAR_W);
      // Last bar absorbs the H_DISP % 8 remainder.
      bar   = (bar_q > CNT_W'(7)) ? 3'd7 : bar_q[2:0];
      color = BAR_TABLE[bar];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs    <= ~HS_POL;
         vs    <= ~VS_POL;
         de    <= 1'b0;
         rgb_r <= '0;
         rgb_g <= '0;
         rgb_b <= '0;
      end else begin
         hs    <= hs_c;
         vs    <= vs_c;
         de    <= de_c;
         rgb_r <= {DATA_WIDTH{de_c & color[2]}};
         rgb_g <= {DATA_WIDTH{de_c & color[1]}};
         rgb_b <= {DATA_WIDTH{de_c & color[0]}};
      end
   end

endmodule

// File: tb/tb_video_color_bar_gen.sv
// Directed bench for video_color_bar_gen: default 480x272 instance plus
// small instances for polarity/remainder, full frame and mid-frame reset.
module tb_video_color_bar_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_s_n = 1'b0;
   logic rst_p_n = 1'b0;

   always #5 clk = ~clk;

   logic       hs, vs, de;
   logic [7:0] r, g, b;
   logic       hs_s, vs_s, de_s;
   logic [7:0] r_s, g_s, b_s;
   logic       hs_p, vs_p, de_p;
   logic [7:0] r_p, g_p, b_p;

   int vectors = 0;
   int errors = 0;

   logic [23:0] exp_bar [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   video_color_bar_gen dut (
      .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .de(de),
      .rgb_r(r), .rgb_g(g), .rgb_b(b));

   // 24 x 9 raster: H 3/2/16/3, V 2/1/4/2, frame = 216 clocks.
   video_color_bar_gen #(
      .H_SYNC(3), .H_BACK(2), .H_DISP(16), .H_FRONT(3), .HS_POL(1'b1),
      .V_SYNC(2), .V_BACK(1), .V_DISP(4), .V_FRONT(2), .VS_POL(1'b1),
      .DATA_WIDTH(8)
   ) dut_s (
      .clk(clk), .rst_n(rst_s_n), .hs(hs_s), .vs(vs_s), .de(de_s),
      .rgb_r(r_s), .rgb_g(g_s), .rgb_b(b_s));

   // Negative polarity, H_DISP = 100: H total 108, V total 7.
   video_color_bar_gen #(
      .H_SYNC(4), .H_BACK(2), .H_DISP(100), .H_FRONT(2), .HS_POL(1'b0),
      .V_SYNC(2), .V_BACK(1), .V_DISP(3), .V_FRONT(1), .VS_POL(1'b0),
      .DATA_WIDTH(8)
   ) dut_p (
      .clk(clk), .rst_n(rst_p_n), .hs(hs_p), .vs(vs_p), .de(de_p),
      .rgb_r(r_p), .rgb_g(g_p), .rgb_b(b_p));

   task automatic test_reset;
      rst_n = 1'b0;
      rst_s_n = 1'b0;
      rst_p_n = 1'b0;
      repeat (10) @(negedge clk);
      vectors++;
      if ({hs, vs, de} !== 3'b000) begin
         errors++;
         $display("FAIL reset_sync: got %b required 000", {hs, vs, de});
      end
      vectors++;
      if ({r, g, b} !== 24'h0) begin
         errors++;
         $display("FAIL reset_rgb: got %h required 000000", {r, g, b});
      end
      vectors++;
      if ({hs_p, vs_p, de_p} !== 3'b110) begin
         errors++;
         $display("FAIL reset_neg_pol: got %b required 110",
                  {hs_p, vs_p, de_p});
      end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({hs, vs, de} !== 3'b110) begin
         errors++;
         $display("FAIL first_edge: got %b required 110", {hs, vs, de});
      end
      vectors++;
      if ({r, g, b} !== 24'h0) begin
         errors++;
         $display("FAIL blank_rgb: got %h required 000000", {r, g, b});
      end
   endtask

   // Entered at position (0,0); leaves at line 1 pixel 0 (clock 525).
   task automatic test_line_timing;
      int n;
      n = 0;
      while (hs === 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n != 41) begin
         errors++;
         $display("FAIL hs_width: got %0d required 41", n);
      end
      while (hs !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n != 525) begin
         errors++;
         $display("FAIL line_period: got %0d required 525", n);
      end
   endtask

   // Leaves at first active pixel of line 12.
   task automatic test_frame_timing;
      int n;
      int rise;
      logic prev;
      n = 525;
      while (vs === 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n != 5250) begin
         errors++;
         $display("FAIL vs_width: got %0d required 5250", n);
      end
      rise = n;
      while (de !== 1'b1 && n < 20000) begin
         prev = hs;
         @(negedge clk);
         n++;
         if (hs === 1'b1 && prev !== 1'b1) rise = n;
      end
      vectors++;
      if (n != 6343) begin
         errors++;
         $display("FAIL first_de_clock: got %0d required 6343 (line 12)", n);
      end
      vectors++;
      if (n - rise != 43) begin
         errors++;
         $display("FAIL hs_to_de: got %0d required 43", n - rise);
      end
   endtask

   task automatic test_bars;
      int bi;
      for (int i = 0; i < 480; i++) begin
         bi = i / 60;
         vectors++;
         if ({de, r, g, b} !== {1'b1, exp_bar[bi]}) begin
            errors++;
            $display("FAIL bar_px%0d: got de=%b rgb=%h required de=1 rgb=%h",
                     i, de, {r, g, b}, exp_bar[bi]);
         end
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if ({de, r, g, b} !== 25'h0) begin
            errors++;
            $display("FAIL blank_after_%0d: got de=%b rgb=%h required 0",
                     i, de, {r, g, b});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_polarity;
      int n;
      int bi;
      logic [23:0] exp;
      rst_p_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({hs_p, vs_p} !== 2'b00) begin
         errors++;
         $display("FAIL neg_pol_active: got %b required 00", {hs_p, vs_p});
      end
      n = 0;
      while (hs_p === 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n != 4) begin
         errors++;
         $display("FAIL neg_hs_width: got %0d required 4", n);
      end
      while (de_p !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n != 330) begin
         errors++;
         $display("FAIL neg_first_de: got %0d required 330", n);
      end
      vectors++;
      if ({hs_p, vs_p} !== 2'b11) begin
         errors++;
         $display("FAIL neg_idle: got %b required 11", {hs_p, vs_p});
      end
      for (int i = 0; i < 100; i++) begin
         bi = (i / 12 > 7) ? 7 : i / 12;
         exp = exp_bar[bi];
         vectors++;
         if ({de_p, r_p, g_p, b_p} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL rem_px%0d: got de=%b rgb=%h required de=1 rgb=%h",
                     i, de_p, {r_p, g_p, b_p}, exp);
         end
         @(negedge clk);
      end
      vectors++;
      if (de_p !== 1'b0) begin
         errors++;
         $display("FAIL rem_de_end: got %b required 0", de_p);
      end
   endtask

   // Called at position (0,0); measures one full frame of dut_s.
   task automatic measure_small_frame(input string tag);
      int n;
      int lines;
      int first;
      logic pv;
      logic pd;
      bit done;
      n = 0;
      lines = 0;
      first = -1;
      done = 0;
      while (!done && n < 1000) begin
         pv = vs_s;
         pd = de_s;
         @(negedge clk);
         n++;
         if (de_s === 1'b1 && pd !== 1'b1) begin
            lines++;
            if (first < 0) first = n;
         end
         if (vs_s === 1'b1 && pv !== 1'b1) done = 1;
      end
      vectors++;
      if (n != 216) begin
         errors++;
         $display("FAIL %s_period: got %0d required 216", tag, n);
      end
      vectors++;
      if (lines != 4) begin
         errors++;
         $display("FAIL %s_de_lines: got %0d required 4", tag, lines);
      end
      vectors++;
      if (first != 77) begin
         errors++;
         $display("FAIL %s_first_de: got %0d required 77", tag, first);
      end
   endtask

   task automatic test_small_frame;
      rst_s_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({hs_s, vs_s, de_s} !== 3'b110) begin
         errors++;
         $display("FAIL small_start: got %b required 110", {hs_s, vs_s, de_s});
      end
      measure_small_frame("frame");
   endtask

   // Entered at (0,0) of dut_s's second frame.
   task automatic test_mid_frame_reset;
      repeat (130) @(negedge clk);
      vectors++;
      if ({de_s, r_s, g_s, b_s} !== {1'b1, 24'h00FFFF}) begin
         errors++;
         $display("FAIL mid_pre: got de=%b rgb=%h required de=1 rgb=00ffff",
                  de_s, {r_s, g_s, b_s});
      end
      rst_s_n = 1'b0;
      #1;
      vectors++;
      if ({hs_s, vs_s, de_s, r_s, g_s, b_s} !== 27'h0) begin
         errors++;
         $display("FAIL mid_async: got hs=%b vs=%b de=%b rgb=%h required 0",
                  hs_s, vs_s, de_s, {r_s, g_s, b_s});
      end
      repeat (3) @(negedge clk);
      rst_s_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({hs_s, vs_s, de_s} !== 3'b110) begin
         errors++;
         $display("FAIL mid_restart: got %b required 110", {hs_s, vs_s, de_s});
      end
      measure_small_frame("restart");
   endtask

   initial begin
      test_reset;
      test_line_timing;
      test_frame_timing;
      test_bars;
      test_polarity;
      test_small_frame;
      test_mid_frame_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
